// File: rtl/i2c_master_writer.sv
// Single-byte I2C write master: START, 7-bit address + W, one data byte, STOP.
// Both bus lines are open-drain; ACK is sampled after the address and after the data byte.
`timescale 1ns/1ps
module i2c_master_writer #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    inout  wire        i2c_scl,
    inout  wire        i2c_sda
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START_C,
        ADDR,
        ACK1,
        DATA,
        ACK2,
        STOP_C
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] tick_cnt;
    logic [1:0]    qtr;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    data_lat;
    logic          tick;
    logic          bit_end;
    logic          scl_low;
    logic          sda_low;

    assign tick    = busy && (tick_cnt == TW'(CLK_DIV - 1));
    assign bit_end = tick && (qtr == 2'd3);

    // Lines are decoded from registered state, so an async reset releases them at once.
    assign i2c_scl = scl_low ? 1'b0 : 1'bz;
    assign i2c_sda = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        scl_low   = 1'b0;
        sda_low   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = START_C;
            end
            START_C: begin
                sda_low = qtr[1];
                scl_low = (qtr == 2'd3);
                if (bit_end) state_nxt = ADDR;
            end
            ADDR, DATA: begin
                scl_low = (qtr == 2'd0) || (qtr == 2'd3);
                sda_low = ~shreg[7];
                if (bit_end && (bit_cnt == 3'd7)) state_nxt = (state == ADDR) ? ACK1 : ACK2;
            end
            ACK1: begin
                scl_low = (qtr == 2'd0) || (qtr == 2'd3);
                // ack_err already holds the q2 sample when the bit ends
                if (bit_end) state_nxt = ack_err ? STOP_C : DATA;
            end
            ACK2: begin
                scl_low = (qtr == 2'd0) || (qtr == 2'd3);
                if (bit_end) state_nxt = STOP_C;
            end
            STOP_C: begin
                scl_low = (qtr == 2'd0);
                sda_low = ~qtr[1];
                if (bit_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
            tick_cnt <= '0;
            qtr      <= '0;
            bit_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    busy     <= 1'b1;
                    ack_err  <= 1'b0;
                    tick_cnt <= '0;
                    qtr      <= '0;
                    bit_cnt  <= '0;
                end
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                if (tick) qtr <= qtr + 2'd1;
                if (tick && (qtr == 2'd2) && ((state == ACK1) || (state == ACK2)) && i2c_sda)
                    ack_err <= 1'b1;
                if (bit_end && ((state == ADDR) || (state == DATA)))
                    bit_cnt <= bit_cnt + 3'd1;
                if (bit_end && (state == STOP_C)) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state == IDLE) && start) begin
            shreg    <= {addr, 1'b0};
            data_lat <= data;
        end else if (bit_end && ((state == ADDR) || (state == DATA))) begin
            shreg <= {shreg[6:0], 1'b0};
        end else if (bit_end && (state == ACK1)) begin
            shreg <= data_lat;
        end
    end

endmodule

// File: tb/tb_i2c_master_writer.sv
// Bench for i2c_master_writer: pulled-up bus, behavioural slave at 0x2A and bus monitor,
// directed and randomized single-byte writes compared against a transaction-level model.
`timescale 1ns/1ps
module tb_i2c_master_writer;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] addr_i = '0;
    logic [7:0] data_i = '0;
    logic       busy;
    logic       done;
    logic       ack_err;
    wire        i2c_scl;
    wire        i2c_sda;

    pullup (i2c_scl);
    pullup (i2c_sda);

    logic slv_sda_low = 1'b0;
    assign i2c_sda = slv_sda_low ? 1'b0 : 1'bz;

    i2c_master_writer #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .addr    (addr_i),
        .data    (data_i),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .i2c_scl (i2c_scl),
        .i2c_sda (i2c_sda)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    bit force_data_nack = 1'b0;

    // Bus monitor + slave state (written only by the monitor process)
    int         start_cnt = 0;
    int         stop_cnt = 0;
    bit         mon_q[$];
    logic [7:0] rx_q[$];
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    logic       m_scl;
    logic       m_sda;
    bit         in_frame = 1'b0;
    bit         ack_ph = 1'b0;
    bit         addressed = 1'b0;
    bit         pend_v = 1'b0;
    bit         pend_bit = 1'b0;
    bit         give;
    int         bitn = 0;
    int         byte_idx = 0;
    logic [7:0] sl_sh = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (done === 1'b1) done_cnt++;
    end

    initial forever begin
        @(negedge clk);
        m_scl = i2c_scl;
        m_sda = i2c_sda;
        if (p_scl && m_scl && p_sda && !m_sda) begin
            start_cnt++;
            in_frame  = 1'b1;
            ack_ph    = 1'b0;
            addressed = 1'b0;
            pend_v    = 1'b0;
            bitn      = 0;
            byte_idx  = 0;
            slv_sda_low <= 1'b0;
        end else if (p_scl && m_scl && !p_sda && m_sda) begin
            stop_cnt++;
            in_frame = 1'b0;
            pend_v   = 1'b0;
            slv_sda_low <= 1'b0;
        end else if (in_frame) begin
            if (!p_scl && m_scl) begin
                pend_bit = m_sda;
                pend_v   = 1'b1;
                if (!ack_ph && bitn < 8) begin
                    sl_sh = {sl_sh[6:0], m_sda};
                    bitn++;
                end
            end
            if (p_scl && !m_scl) begin
                if (pend_v) mon_q.push_back(pend_bit);
                pend_v = 1'b0;
                if (ack_ph) begin
                    ack_ph   = 1'b0;
                    bitn     = 0;
                    byte_idx++;
                    slv_sda_low <= 1'b0;
                end else if (bitn == 8) begin
                    ack_ph = 1'b1;
                    if (byte_idx == 0) begin
                        addressed = (sl_sh == {7'h2A, 1'b0});
                        give = addressed;
                    end else begin
                        give = addressed && !force_data_nack;
                        if (give) rx_q.push_back(sl_sh);
                    end
                    slv_sda_low <= give;
                end
            end
        end
        p_scl = m_scl;
        p_sda = m_sda;
    end

    int base_st, base_sp, base_mb, base_rx, base_dc, t_acc, lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Transaction-level expectation: bits seen on the bus, error flag, length in quarter ticks
    task automatic model(input logic [6:0] a, input logic [7:0] d, input bit fn,
                         output logic [31:0] bits, output int nbits, output bit err,
                         output int quarters);
        logic [7:0] ab;
        ab = {a, 1'b0};
        bits = '0;
        nbits = 0;
        for (int i = 7; i >= 0; i--) begin bits = {bits[30:0], ab[i]}; nbits++; end
        if (a == 7'h2A) begin
            bits = {bits[30:0], 1'b0}; nbits++;
            for (int i = 7; i >= 0; i--) begin bits = {bits[30:0], d[i]}; nbits++; end
            bits = {bits[30:0], fn}; nbits++;
            err = fn;
            quarters = 4 + 36 + 36 + 4;
        end else begin
            bits = {bits[30:0], 1'b1}; nbits++;
            err = 1'b1;
            quarters = 4 + 36 + 4;
        end
    endtask

    task automatic snap();
        base_st = start_cnt;
        base_sp = stop_cnt;
        base_mb = mon_q.size();
        base_rx = rx_q.size();
        base_dc = done_cnt;
    endtask

    task automatic launch(input logic [6:0] a, input logic [7:0] d, input bit hold);
        @(negedge clk);
        addr_i = a;
        data_i = d;
        start  = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        t_acc = cyc;
        chk("busy_after_accept", busy, 1'b1);
    endtask

    task automatic wait_done(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin got = 1'b1; break; end
        end
        chk({tag, "_done_seen"}, got, 1'b1);
        lat = cyc - t_acc;
    endtask

    task automatic check_result(input string tag, input logic [6:0] a, input logic [7:0] d,
                                input bit fn, input bit one);
        logic [31:0] eb, ob;
        int          en, q;
        bit          eerr;
        model(a, d, fn, eb, en, eerr, q);
        chk_rng({tag, "_latency"}, lat, q * CLK_DIV - 1, q * CLK_DIV + 1);
        chk({tag, "_ack_err"}, ack_err, eerr);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        ob = '0;
        for (int i = base_mb; i < mon_q.size(); i++) ob = {ob[30:0], mon_q[i]};
        chk({tag, "_nbits"}, mon_q.size() - base_mb, en);
        chk({tag, "_bits"}, ob, eb);
        chk({tag, "_starts"}, start_cnt - base_st, 1);
        chk({tag, "_stops"}, stop_cnt - base_sp, 1);
        chk({tag, "_rx_count"}, rx_q.size() - base_rx, !eerr);
        if (!eerr && rx_q.size() > base_rx) chk({tag, "_rx_byte"}, rx_q[base_rx], d);
        if (one) begin
            @(negedge clk);
            chk({tag, "_done_pulse"}, done, 1'b0);
            chk({tag, "_done_count"}, done_cnt - base_dc, 1);
        end
    endtask

    task automatic do_xfer(input string tag, input logic [6:0] a, input logic [7:0] d, input bit fn);
        force_data_nack = fn;
        snap();
        launch(a, d, 1'b0);
        wait_done(tag);
        check_result(tag, a, d, fn, 1'b1);
        force_data_nack = 1'b0;
    endtask

    initial begin
        logic [6:0] ra;
        logic [7:0] rd;
        bit         rf;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ack_err", ack_err, 1'b0);
        chk("rst_scl_released", i2c_scl, 1'b1);
        chk("rst_sda_released", i2c_sda, 1'b1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_xfer("ack", 7'h2A, 8'hA5, 1'b0);
        do_xfer("addr_nack", 7'h15, 8'h77, 1'b0);
        do_xfer("data_nack", 7'h2A, 8'hC3, 1'b1);

        // Second request during the address phase must be dropped
        snap();
        launch(7'h2A, 8'hA5, 1'b0);
        while (cyc - t_acc < 60) @(negedge clk);
        data_i = 8'h3C;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rej_busy", busy, 1'b1);
        wait_done("rej");
        check_result("rej", 7'h2A, 8'hA5, 1'b0, 1'b1);

        // Reset during data bit 3 (its q0, SCL low)
        snap();
        launch(7'h2A, 8'hA5, 1'b0);
        while (cyc - t_acc < 209) @(negedge clk);
        chk("mid_scl_low", i2c_scl, 1'b0);
        chk("mid_sda_low", i2c_sda, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_scl", i2c_scl, 1'b1);
        chk("rst_mid_sda", i2c_sda, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid_no_done", done_cnt - base_dc, 0);
        do_xfer("post_rst", 7'h2A, 8'h5A, 1'b0);

        // Start held high across done: two transfers one idle cycle apart
        snap();
        launch(7'h2A, 8'h11, 1'b1);
        wait_done("b2b1");
        check_result("b2b1", 7'h2A, 8'h11, 1'b0, 1'b0);
        data_i = 8'h22;
        @(negedge clk);
        chk("b2b_busy_again", busy, 1'b1);
        chk("b2b_done_low", done, 1'b0);
        start = 1'b0;
        t_acc = cyc;
        wait_done("b2b2");
        chk_rng("b2b2_latency", lat, 80 * CLK_DIV - 1, 80 * CLK_DIV + 1);
        @(negedge clk);
        chk("b2b_done_count", done_cnt - base_dc, 2);
        chk("b2b_starts", start_cnt - base_st, 2);
        chk("b2b_rx_count", rx_q.size() - base_rx, 2);
        if (rx_q.size() >= base_rx + 2) begin
            chk("b2b_rx0", rx_q[base_rx], 8'h11);
            chk("b2b_rx1", rx_q[base_rx + 1], 8'h22);
        end

        for (int k = 0; k < 6; k++) begin
            ra = ($urandom_range(0, 1) == 1) ? 7'h2A : 7'($urandom);
            rd = 8'($urandom);
            rf = 1'($urandom_range(0, 1));
            do_xfer("rand", ra, rd, rf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_master_writer.md
# i2c_master_writer

Single-byte I2C write master that drives the shared open-drain `i2c_scl`/`i2c_sda` bus. It sits directly upstream of the I2C slave receiver (address 7'b0101010). On a one-cycle `start` request it issues START, the 7-bit address with R/W=0, one data byte and STOP. It checks the slave ACK after the address and after the data byte, and reports the result on `done`/`ack_err`.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per quarter-bit tick; must be ≥2. One SCL bit period is 4×`CLK_DIV` clk cycles.
- `clk`  input  1  system clock; all logic is on its rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `start`  input  1  transfer request; sampled only while `busy`=0.
- `addr`  input  7  target slave address; latched when `start` is accepted.
- `data`  input  8  byte to write; latched when `start` is accepted.
- `busy`  output  1  high from the cycle after acceptance until the `done` cycle.
- `done`  output  1  one-cycle pulse when STOP completes.
- `ack_err`  output  1  valid with `done`: 1 means a NACK was received. Holds its value until the next acceptance.
- `i2c_scl`  inout  1  open-drain: drives 0 or Z, never drives 1.
- `i2c_sda`  inout  1  open-drain: drives 0 or Z, never drives 1.

## Operation
- Reset values: `busy`=0, `done`=0, `ack_err`=0, SCL and SDA released (Z), state IDLE, tick and bit counters 0.
- Tick generator: a counter runs 0..`CLK_DIV`-1 only while `busy`=1. A tick occurs on wrap. Each bit has 4 quarter phases, q0–q3.
- State IDLE:
  - Lines are released.
  - `start`=1 latches `addr` and `data` into an 8-bit shift register {addr, 1'b0}, clears `ack_err`, and moves to START_C.
- State START_C (4 ticks):
  - q0 and q1: SDA=Z, SCL=Z.
  - q2: SDA=0 while SCL=Z, which is the start condition.
  - q3: SCL=0.
- State ADDR (8 bits, MSB first), per bit:
  - q0: SCL=0; SDA gets the shift-register MSB (0 → drive 0, 1 → Z).
  - q1 and q2: SCL=Z.
  - q3: SCL=0, then shift left.
- State ACK1 (1 bit):
  - q0: SDA=Z.
  - q2: sample `i2c_sda`. 0 means ACK: load `data` into the shift register and go to DATA. 1 means NACK: set `ack_err`=1 and go to STOP_C.
- State DATA: identical to ADDR, 8 bits MSB first.
- State ACK2: identical sampling to ACK1. A NACK sets `ack_err`. Either result goes to STOP_C.
- State STOP_C (4 ticks):
  - q0: SCL=0, SDA=0.
  - q1: SCL=Z.
  - q2: SDA=Z while SCL is high, which is the stop condition.
  - q3: hold.
  - End of q3: `done`=1 for one cycle, `busy`=0, return to IDLE.
- No clock stretching and no arbitration. SCL readback is ignored.
- `start` while `busy`=1 is ignored with no queuing. `start` held high across `done` starts a new transfer in the cycle after `done`.
- Reset mid-transfer: both lines are released in the same instant (asynchronous), the FSM goes to IDLE, and `done` is not pulsed. A spurious STOP/START on the bus is accepted.

## Timing
- Acceptance edge N: `busy`=1 at N+1.
- ACK path, start to `done`:
  - 80 ticks = 4 + 36 + 36 + 4.
  - `done` at acceptance + 80×`CLK_DIV` cycles, ±1 cycle for the registered output.
- Address NACK, start to `done`: 44 ticks (4 + 36 + 4).
- SDA changes only at q0 of a bit (SCL low). The only exceptions are the START and STOP edges at q2 with SCL high.
- The slave samples on the SCL rising edge at the q1 boundary. Its ACK, driven after SCL falls, is stable by q2.
- Minimum back-to-back gap between transfers: 1 IDLE cycle.

## Test plan
- ACK path, `CLK_DIV`=4, pullups on both lines, slave model at 0x2A: `start` with addr=0x2A, data=0xA5 → SDA bit sequence 0,1,0,1,0,1,0,0 | ACK | 1,0,1,0,0,1,0,1 | ACK, START/STOP seen. `done` after 320±1 cycles, `ack_err`=0, slave `dataout`=0xA5.
- Address NACK: addr=0x15 with slave at 0x2A → no slave ACK, STOP issued. `done` after 176±1 cycles, `ack_err`=1.
- Data NACK: slave model forced to NACK the data byte → `ack_err`=1 with `done`, STOP still generated.
- Busy rejection: second `start` pulse (data=0x3C) in the middle of the address phase → ignored. Only 0xA5 is transferred and one `done` pulse is seen.
- Reset mid-data: assert `rst` during data bit 3 → SCL/SDA go Z immediately, `busy`=0, no `done`. A subsequent transfer with data=0x5A completes correctly.
- Back-to-back: `start` held high → two transfers separated by 1 idle cycle, two `done` pulses, slave receives both bytes in order.
